y_line_fetch: RTL

Fetch stage directly downstream of the Y-matrix address decoder. It accepts the address pair the decoder produces (first and second Y line addresses) and issues the reads to the single-port Y SRAM. SRAM read latency is one cycle. It captures the returned 256-bit lines into a holding buffer and hands both lines to the compute stage over a valid/ready handshake. It also keeps a saturating count of SRAM reads issued.

---
 rtl/y_line_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/y_line_fetch.sv
// Y line fetch: reads one or two lines from the single-port Y SRAM for each
// decoded address pair and holds them for the compute stage until accepted.
//
// state | meaning
// IDLE  | ready for a new address pair
// RD1   | issue the read of addr1
// RD2   | issue the read of addr2 (double mode only)
// CAP   | capture returning SRAM data into the holding buffer
// HOLD  | present both lines until out_ready
module y_line_fetch #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic              req_single,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [CNT_W-1:0]  rd_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] RD2  = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  localparam logic [1:0] M_DOUBLE = 2'd0;
  localparam logic [1:0] M_SINGLE = 2'd1;
  localparam logic [1:0] M_DUP    = 2'd2;

  logic [2:0]        state;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] addr2_q;
  logic              en_line;
  logic              rvalid;
  logic              rline;
  logic              last_line;

  assign req_ready = reset && (state == IDLE);

  // The read that returns last is line 2 in double mode, line 1 otherwise.
  assign last_line = (mode != M_DOUBLE) || rline;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= M_DOUBLE;
      addr1_q   <= '0;
      addr2_q   <= '0;
      sram_en   <= 1'b0;
      sram_addr <= '0;
      en_line   <= 1'b0;
      rvalid    <= 1'b0;
      rline     <= 1'b0;
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      rd_count  <= '0;
    end else begin
      sram_en <= 1'b0;
      // rvalid/rline mark the cycle in which sram_rdata carries a read result.
      rvalid  <= sram_en;
      rline   <= en_line;

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr1_q <= req_addr1;
            addr2_q <= req_addr2;
            if (req_single)
              mode <= M_SINGLE;
            else if (req_addr1 == req_addr2)
              mode <= M_DUP;
            else
              mode <= M_DOUBLE;
            state <= RD1;
          end
        end

        RD1: begin
          sram_en   <= 1'b1;
          sram_addr <= addr1_q;
          en_line   <= 1'b0;
          if (rd_count != '1)
            rd_count <= rd_count + CNT_W'(1);
          state <= (mode == M_DOUBLE) ? RD2 : CAP;
        end

        RD2: begin
          sram_en   <= 1'b1;
          sram_addr <= addr2_q;
          en_line   <= 1'b1;
          if (rd_count != '1)
            rd_count <= rd_count + CNT_W'(1);
          state <= CAP;
        end

        CAP: begin
          if (rvalid) begin
            if (!rline) begin
              out_data1 <= sram_rdata;
              if (mode == M_SINGLE)
                out_data2 <= '0;
              else if (mode == M_DUP)
                out_data2 <= sram_rdata;
            end else begin
              out_data2 <= sram_rdata;
            end
            if (last_line) begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
